// File: rtl/port_deserializer.sv
// rtl/port_deserializer.sv - per-port serial-to-word assembler with one-word buffers and a round-robin tagged output.
// Optional PARTIAL_FLUSH_EN: deliver left-justified partial words at frame end and add out_len.
module port_deserializer #(
    parameter int PW   = 2,
    parameter int WORD = 8,
    localparam int NPORTS = 2**PW,
    localparam int LW     = $clog2(WORD+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              SerOut,
    input  logic              SerOutValid,
    input  logic [PW-1:0]     Port,
    input  logic              Done,
    input  logic              out_ready,
    input  logic              err_clr,
    output logic              out_valid,
    output logic [WORD-1:0]   out_data,
    output logic [PW-1:0]     out_port,
    output logic [NPORTS-1:0] err
`ifdef PARTIAL_FLUSH_EN
    ,
    output logic [LW-1:0]     out_len
`endif
);
    localparam int CW = $clog2(WORD);

    logic [WORD-1:0]   acc_q  [NPORTS];
    logic [WORD-1:0]   acc_d  [NPORTS];
    logic [CW-1:0]     cnt_q  [NPORTS];
    logic [CW-1:0]     cnt_d  [NPORTS];
    logic [WORD-1:0]   hold_q [NPORTS];
    logic [WORD-1:0]   hold_d [NPORTS];
    logic [NPORTS-1:0] pend_q, pend_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD-1:0]   out_data_q, out_data_d;
    logic [PW-1:0]     out_port_q, out_port_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [PW-1:0]     last_port_q, last_port_d;
    logic              done_q, done_d;
    logic [NPORTS-1:0] err_q, err_d;

    logic              load_en;
    logic              sel_found;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     idx;
    logic [WORD-1:0]   shifted;
    logic              offer;
    logic [PW-1:0]     offer_port;
    logic [WORD-1:0]   offer_word;
    logic [PW-1:0]     fp;

`ifdef PARTIAL_FLUSH_EN
    logic [LW-1:0]     hold_len_q [NPORTS];
    logic [LW-1:0]     hold_len_d [NPORTS];
    logic [LW-1:0]     out_len_q, out_len_d;
    logic [LW-1:0]     offer_len;
    int                flush_sh;
`endif

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        rr_d        = rr_q;
        last_port_d = last_port_q;
        done_d      = Done;
        err_d       = err_clr ? '0 : err_q;
        load_en     = !out_valid_q || out_ready;
        sel_found   = 1'b0;
        sel         = '0;
        idx         = '0;
        shifted     = '0;
        offer       = 1'b0;
        offer_port  = Port;
        offer_word  = '0;
        fp          = '0;
`ifdef PARTIAL_FLUSH_EN
        hold_len_d  = hold_len_q;
        out_len_d   = out_len_q;
        offer_len   = LW'(WORD);
        flush_sh    = 0;
`endif

        // Round-robin pick among ports that were pending before this edge.
        for (int i = 0; i < NPORTS; i++) begin
            idx = rr_q + PW'(i);
            if (!sel_found && pend_q[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end

        if (load_en) begin
            out_valid_d = sel_found;
            if (sel_found) begin
                out_data_d  = hold_q[sel];
                out_port_d  = sel;
                pend_d[sel] = 1'b0;
                rr_d        = sel + PW'(1);
`ifdef PARTIAL_FLUSH_EN
                out_len_d   = hold_len_q[sel];
`endif
            end
        end

        if (SerOutValid) begin
            shifted     = {acc_q[Port][WORD-2:0], SerOut};
            acc_d[Port] = shifted;
            last_port_d = Port;
            if (cnt_q[Port] == CW'(WORD-1)) begin
                cnt_d[Port] = '0;
                offer       = 1'b1;
                offer_word  = shifted;
            end else begin
                cnt_d[Port] = cnt_q[Port] + CW'(1);
            end
        end

        // Frame end acts on the post-capture view, so a coincident bit is included.
        if (Done && !done_q) begin
            fp = last_port_d;
`ifdef PARTIAL_FLUSH_EN
            if (cnt_d[fp] != '0) begin
                flush_sh   = WORD - int'(cnt_d[fp]);
                offer      = 1'b1;
                offer_port = fp;
                offer_word = acc_d[fp] << flush_sh;
                offer_len  = LW'(cnt_d[fp]);
            end
`endif
            cnt_d[fp] = '0;
            acc_d[fp] = '0;
        end

        if (offer) begin
            if (!pend_q[offer_port] || (load_en && sel_found && sel == offer_port)) begin
                hold_d[offer_port] = offer_word;
                pend_d[offer_port] = 1'b1;
`ifdef PARTIAL_FLUSH_EN
                hold_len_d[offer_port] = offer_len;
`endif
            end else begin
                err_d[offer_port] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPORTS; i++) begin
                acc_q[i]  <= '0;
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
`ifdef PARTIAL_FLUSH_EN
                hold_len_q[i] <= '0;
`endif
            end
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            rr_q        <= '0;
            last_port_q <= '0;
            done_q      <= 1'b0;
            err_q       <= '0;
`ifdef PARTIAL_FLUSH_EN
            out_len_q   <= '0;
`endif
        end else if (clkEn) begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            rr_q        <= rr_d;
            last_port_q <= last_port_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef PARTIAL_FLUSH_EN
            hold_len_q  <= hold_len_d;
            out_len_q   <= out_len_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;
    assign err       = err_q;
`ifdef PARTIAL_FLUSH_EN
    assign out_len   = out_len_q;
`endif

endmodule
